// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory bus plus the IF/ID pipeline register outputs.
//   master : fetch stage side, which drives imem_addr and if_id_*; reads imem_data
//   slave  : memory/decode side, which drives imem_data; reads everything else
interface if_stage_if;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;

  modport master (
    output imem_addr, if_id_pc, if_id_instr, if_id_valid,
    input  imem_data
  );
  modport slave (
    input  imem_addr, if_id_pc, if_id_instr, if_id_valid,
    output imem_data
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch for the 5-stage RV64 pipeline.
// Owns the PC, presents it on the imem bus, and registers the fetched word into IF/ID.
// Per-edge priority: reset > redirect > stall > normal fetch.
//   clk, reset        : clock; synchronous active-low reset
//   stall             : hold PC and IF/ID
//   branch_taken/target : redirect the PC and flush IF/ID with a NOP bubble
//   bus (master)      : imem_addr/imem_data and the IF/ID outputs
//   fetch_fault       : sticky flag for a misaligned redirect target
//   *_count           : saturating fetch/stall/flush cycle counters
module if_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [63:0]      branch_target,
  if_stage_if.master       bus,
  output logic             fetch_fault,
  output logic [CNT_W-1:0] fetch_count,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  logic [63:0]      pc_q, pc_d;
  if_id_t           if_id_q, if_id_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    pc_d        = pc_q;
    if_id_d     = if_id_q;
    fault_d     = fault_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (branch_taken) begin
      // Low bits are dropped so the PC stays word aligned; misalignment is only flagged.
      pc_d        = {branch_target[63:2], 2'b00};
      if_id_d     = '{pc: 64'h0, instr: NOP_INSTR, valid: 1'b0};
      fault_d     = fault_q | (branch_target[1:0] != 2'b00);
      flush_cnt_d = sat_inc(flush_cnt_q);
    end else if (stall) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      if_id_d     = '{pc: pc_q, instr: bus.imem_data, valid: 1'b1};
      pc_d        = pc_q + 64'd4;  // wraps modulo 2^64
      fetch_cnt_d = sat_inc(fetch_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q        <= RESET_PC;
      if_id_q     <= '{pc: 64'h0, instr: NOP_INSTR, valid: 1'b0};
      fault_q     <= 1'b0;
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      if_id_q     <= if_id_d;
      fault_q     <= fault_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.if_id_pc    = if_id_q.pc;
  assign bus.if_id_instr = if_id_q.instr;
  assign bus.if_id_valid = if_id_q.valid;
  assign fetch_fault     = fault_q;
  assign fetch_count     = fetch_cnt_q;
  assign stall_count     = stall_cnt_q;
  assign flush_count     = flush_cnt_q;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: two instances, one with defaults and one with a wrap-around
// reset PC and 2-bit counters, driven by the same inputs.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [63:0] branch_target;
  logic        fault0, fault1;
  logic [31:0] fc0, sc0, flc0;
  logic [1:0]  fc1, sc1, flc1;

  if_stage_if bus0();
  if_stage_if bus1();
  assign bus0.imem_data = bus0.imem_addr[31:0] + 32'h100;
  assign bus1.imem_data = bus1.imem_addr[31:0] + 32'h100;

  always #5 clk = ~clk;

  if_stage dut0 (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .bus(bus0.master), .fetch_fault(fault0),
    .fetch_count(fc0), .stall_count(sc0), .flush_count(flc0)
  );
  if_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .bus(bus1.master), .fetch_fault(fault1),
    .fetch_count(fc1), .stall_count(sc1), .flush_count(flc1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: architectural state after each edge.
  typedef struct {
    logic [63:0] pc, ifpc;
    logic [31:0] instr;
    logic        v, fault;
    longint      fc, sc, flc;
  } mstate_t;
  mstate_t m0, m1;

  function automatic mstate_t model_step(mstate_t s, logic rst, logic st, logic bt,
                                         logic [63:0] tgt, logic [63:0] rpc, longint cmax);
    mstate_t n = s;
    if (!rst) begin
      n.pc = rpc; n.ifpc = 0; n.instr = 32'h13; n.v = 0; n.fault = 0;
      n.fc = 0; n.sc = 0; n.flc = 0;
    end else if (bt) begin
      n.pc = tgt - (tgt % 4);
      n.ifpc = 0; n.instr = 32'h13; n.v = 0;
      if (tgt % 4 != 0) n.fault = 1;
      if (s.flc < cmax) n.flc = s.flc + 1;
    end else if (st) begin
      if (s.sc < cmax) n.sc = s.sc + 1;
    end else begin
      n.ifpc = s.pc; n.instr = s.pc[31:0] + 32'h100; n.v = 1;
      n.pc = s.pc + 4;
      if (s.fc < cmax) n.fc = s.fc + 1;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic bt, input logic [63:0] tgt);
    @(negedge clk);
    reset = rst; stall = st; branch_taken = bt; branch_target = tgt;
    @(posedge clk);
    m0 = model_step(m0, rst, st, bt, tgt, 64'h0, 64'hFFFF_FFFF);
    m1 = model_step(m1, rst, st, bt, tgt, 64'hFFFF_FFFF_FFFF_FFFC, 3);
    #1;
  endtask

  task automatic chk_model0(input string tag);
    chk({tag, " d0 imem_addr"}, bus0.imem_addr, m0.pc);
    chk({tag, " d0 if_id_pc"}, bus0.if_id_pc, m0.ifpc);
    chk({tag, " d0 if_id_instr"}, {32'h0, bus0.if_id_instr}, {32'h0, m0.instr});
    chk({tag, " d0 valid"}, {63'h0, bus0.if_id_valid}, {63'h0, m0.v});
    chk({tag, " d0 fault"}, {63'h0, fault0}, {63'h0, m0.fault});
    chk({tag, " d0 counts"}, {16'h0, fc0[15:0], sc0[15:0], flc0[15:0]},
        {16'h0, m0.fc[15:0], m0.sc[15:0], m0.flc[15:0]});
  endtask

  task automatic chk_model1(input string tag);
    chk({tag, " d1 imem_addr"}, bus1.imem_addr, m1.pc);
    chk({tag, " d1 if_id_pc"}, bus1.if_id_pc, m1.ifpc);
    chk({tag, " d1 if_id_instr"}, {32'h0, bus1.if_id_instr}, {32'h0, m1.instr});
    chk({tag, " d1 valid"}, {63'h0, bus1.if_id_valid}, {63'h0, m1.v});
    chk({tag, " d1 fault"}, {63'h0, fault1}, {63'h0, m1.fault});
    chk({tag, " d1 counts"}, {58'h0, fc1, sc1, flc1},
        {58'h0, m1.fc[1:0], m1.sc[1:0], m1.flc[1:0]});
  endtask

  typedef struct {
    logic        rst, st, bt;
    logic [63:0] tgt;
    logic [63:0] e_pc, e_ifpc;
    logic [31:0] e_instr;
    logic        e_v, e_fault;
    int          e_fc, e_sc, e_flc;
  } vec_t;

  function automatic vec_t mk(logic rst, logic st, logic bt, logic [63:0] tgt,
                              logic [63:0] pc, logic [63:0] ifpc, logic [31:0] ins,
                              logic v, logic f, int fc, int sc, int flc);
    vec_t r;
    r.rst = rst; r.st = st; r.bt = bt; r.tgt = tgt;
    r.e_pc = pc; r.e_ifpc = ifpc; r.e_instr = ins; r.e_v = v; r.e_fault = f;
    r.e_fc = fc; r.e_sc = sc; r.e_flc = flc;
    return r;
  endfunction

  vec_t tbl[16];

  initial begin
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    //             rst st bt tgt      pc      ifpc    instr     v f  fc sc flc
    tbl[0]  = mk(0, 0, 0, 64'h0,   64'h0,   64'h0,   32'h13,  0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 64'h0,   64'h4,   64'h0,   32'h100, 1, 0, 1, 0, 0);
    tbl[2]  = mk(1, 0, 0, 64'h0,   64'h8,   64'h4,   32'h104, 1, 0, 2, 0, 0);
    tbl[3]  = mk(1, 1, 0, 64'h0,   64'h8,   64'h4,   32'h104, 1, 0, 2, 1, 0);
    tbl[4]  = mk(1, 1, 0, 64'h0,   64'h8,   64'h4,   32'h104, 1, 0, 2, 2, 0);
    tbl[5]  = mk(1, 1, 0, 64'h0,   64'h8,   64'h4,   32'h104, 1, 0, 2, 3, 0);
    tbl[6]  = mk(1, 0, 0, 64'h0,   64'hC,   64'h8,   32'h108, 1, 0, 3, 3, 0);
    tbl[7]  = mk(1, 0, 0, 64'h0,   64'h10,  64'hC,   32'h10C, 1, 0, 4, 3, 0);
    tbl[8]  = mk(1, 1, 1, 64'h200, 64'h200, 64'h0,   32'h13,  0, 0, 4, 3, 1);
    tbl[9]  = mk(1, 0, 0, 64'h0,   64'h204, 64'h200, 32'h300, 1, 0, 5, 3, 1);
    tbl[10] = mk(1, 0, 1, 64'h203, 64'h200, 64'h0,   32'h13,  0, 1, 5, 3, 2);
    tbl[11] = mk(1, 0, 0, 64'h0,   64'h204, 64'h200, 32'h300, 1, 1, 6, 3, 2);
    tbl[12] = mk(1, 0, 1, 64'h400, 64'h400, 64'h0,   32'h13,  0, 1, 6, 3, 3);
    tbl[13] = mk(1, 1, 0, 64'h0,   64'h400, 64'h0,   32'h13,  0, 1, 6, 4, 3);
    tbl[14] = mk(0, 1, 0, 64'h0,   64'h0,   64'h0,   32'h13,  0, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 0, 64'h0,   64'h4,   64'h0,   32'h100, 1, 0, 1, 0, 0);

    for (int i = 0; i < 16; i++) begin
      string t;
      t = $sformatf("tbl%0d", i);
      step(tbl[i].rst, tbl[i].st, tbl[i].bt, tbl[i].tgt);
      chk({t, " imem_addr"}, bus0.imem_addr, tbl[i].e_pc);
      chk({t, " if_id_pc"}, bus0.if_id_pc, tbl[i].e_ifpc);
      chk({t, " if_id_instr"}, {32'h0, bus0.if_id_instr}, {32'h0, tbl[i].e_instr});
      chk({t, " valid"}, {63'h0, bus0.if_id_valid}, {63'h0, tbl[i].e_v});
      chk({t, " fault"}, {63'h0, fault0}, {63'h0, tbl[i].e_fault});
      chk({t, " fetch_count"}, {32'h0, fc0}, 64'(tbl[i].e_fc));
      chk({t, " stall_count"}, {32'h0, sc0}, 64'(tbl[i].e_sc));
      chk({t, " flush_count"}, {32'h0, flc0}, 64'(tbl[i].e_flc));
      chk_model1(t);
    end

    // PC wrap and 2-bit counter saturation on the second instance.
    step(0, 0, 0, 64'h0);
    chk("wrap reset pc", bus1.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 0, 0, 64'h0);
    chk("wrap first if_id_pc", bus1.if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap pc to zero", bus1.imem_addr, 64'h0);
    step(1, 0, 0, 64'h0);
    chk("wrap second if_id_pc", bus1.if_id_pc, 64'h0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 64'h0);
    chk("fetch_count saturates", {62'h0, fc1}, 64'd3);
    chk_model1("sat");
    // Redirect and stall in the same cycle as reset: reset wins.
    step(0, 1, 1, 64'h123);
    chk("reset beats redirect fault", {63'h0, fault1}, 64'h0);
    chk("reset beats redirect pc", bus1.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk_model0("rstbt");

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      logic r, s, b;
      logic [63:0] tg;
      r  = ($urandom_range(0, 39) != 0);
      s  = ($urandom_range(0, 2) == 0);
      b  = ($urandom_range(0, 4) == 0);
      tg = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 0) tg[63:16] = '0;
      step(r, s, b, tg);
      chk_model0($sformatf("rnd%0d", i));
      chk_model1($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage RV64 pipeline: owns the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register consumed by the decode stage. It accepts a stall from the hazard unit and a taken-branch redirect from the execute stage. On a redirect it flushes the in-flight fetch by inserting a NOP bubble. Saturating performance counters track fetched, stalled and flushed cycles.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset
- CNT_W, 32, width of each performance counter
- NOP_INSTR, 32'h00000013, bubble word (addi x0,x0,0) inserted on flush/reset

- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  synchronous, active-low reset (sampled on rising clk edge when 0)
- stall  in  1  hazard-unit request to hold PC and IF/ID
- branch_taken  in  1  execute-stage redirect request
- branch_target  in  64  redirect address
- imem_data  in  32  instruction word at imem_addr (combinational memory read)
- imem_addr  out  64  current PC; equals the internal PC register
- if_id_pc  out  64  PC of the registered instruction
- if_id_instr  out  32  registered instruction
- if_id_valid  out  1  1 = if_id_instr is a real fetch, 0 = bubble
- fetch_fault  out  1  sticky: a misaligned branch_target was received
- fetch_count  out  CNT_W  number of normal fetch cycles
- stall_count  out  CNT_W  number of stalled cycles
- flush_count  out  CNT_W  number of redirect cycles

## Operation
- Each rising clk edge performs exactly one of, in priority order: reset, redirect, stall, normal.
- Reset (reset==0): pc<=RESET_PC; if_id_pc<=0; if_id_instr<=NOP_INSTR; if_id_valid<=0; fetch_fault<=0; all counters<=0.
- Redirect (branch_taken==1, overrides stall): pc<={branch_target[63:2],2'b00}; if_id_instr<=NOP_INSTR; if_id_pc<=0; if_id_valid<=0; flush_count+=1. If branch_target[1:0]!=0, fetch_fault<=1 (sticky until reset); redirect still taken with low bits cleared.
- Stall (stall==1, branch_taken==0): pc, if_id_pc, if_id_instr, if_id_valid hold; stall_count+=1.
- Normal: if_id_pc<=pc; if_id_instr<=imem_data; if_id_valid<=1; pc<=pc+64'd4; fetch_count+=1.
- PC increment is modulo 2^64: pc 64'hFFFF_FFFF_FFFF_FFFC + 4 -> 64'h0, no flag.
- Counters saturate at 2^CNT_W-1; no wrap.
- imem_addr is combinationally equal to pc; imem_data is not registered before IF/ID.

## Timing
- Fetch latency: address presented in cycle N, instruction visible on if_id_instr after edge ending cycle N (1 cycle).
- Redirect: branch_taken sampled at edge E; imem_addr=target from E onward; the target instruction reaches IF/ID at edge E+1; IF/ID holds a bubble during cycle between E and E+1.
- Stall held for K cycles freezes all outputs except stall_count for K edges; fetch resumes at the held PC with no skipped or duplicated instruction.
- stall and branch_taken asserted together: redirect behaviour only; stall_count unchanged.
- reset asserted mid-stall or mid-redirect: reset wins on that edge; first fetch after deassertion uses RESET_PC.
- All outputs are register outputs (except imem_addr = pc register); no combinational input-to-output paths.

## Test plan
- Reset then 4 normal cycles, imem returns 0x100+addr -> if_id_pc 0,4,8,12 with matching instrs, valid=1, fetch_count=4.
- Stall for 3 cycles at pc=8 -> if_id_pc stays 4, imem_addr stays 8, stall_count=3, next fetch is pc=8.
- branch_taken with target 0x200 while stall=1 -> if_id_instr=0x00000013, valid=0, imem_addr=0x200, flush_count=1, stall_count unchanged; next edge if_id_pc=0x200.
- Target 0x203 -> pc=0x200, fetch_fault=1 and stays 1 through later redirects until reset.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, 2 normal cycles -> if_id_pc FFFF…FFFC then 0; CNT_W=2 with 5 fetches -> fetch_count saturates at 3.
- reset low during stall -> all outputs at reset values on that edge, counters 0.
